// File: rtl/pool_pkg.sv
// pool_pkg: tap index constants and the (row,col) -> 9-bit tap-select mask builder
// shared by pool_window_gen and the POOLING bench.
package pool_pkg;
    localparam int TAP_TL  = 0;
    localparam int TAP_TC  = 1;
    localparam int TAP_TR  = 2;
    localparam int TAP_ML  = 3;
    localparam int TAP_MC  = 4;
    localparam int TAP_MR  = 5;
    localparam int TAP_BL  = 6;
    localparam int TAP_BC  = 7;
    localparam int TAP_CUR = 8;
    localparam logic [8:0] SEL_ALL = 9'h1FF;

    // Tap k sits at (row-(2-k/3), col-(2-k%3)); it is live only when both land inside the image.
    function automatic logic [8:0] sel_mask(input int row, input int col);
        logic [8:0] m;
        for (int k = 0; k < 9; k++) m[k] = (row >= 2 - k / 3) && (col >= 2 - k % 3);
        return m;
    endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one image line of pixels, combinational read and synchronous write at the
// same index. Contents are not reset; stale entries are masked downstream.
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter  int BIT_WIDTH = 8,
    parameter  int DEPTH     = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [BIT_WIDTH-1:0] wdata_i,
    output logic [BIT_WIDTH-1:0] rdata_o
);
    logic [BIT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];
endmodule

// File: rtl/pool_window_gen.sv
// pool_window_gen: raster pixel stream -> registered 3x3 window + tap-select mask per pixel.
// POOL_WIN_PAD_EN defined: every pixel emits an edge-masked window; undefined: only r>=2 && c>=2.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_sof,
    input  logic [BIT_WIDTH-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BIT_WIDTH-1:0] win0,
    output logic [BIT_WIDTH-1:0] win1,
    output logic [BIT_WIDTH-1:0] win2,
    output logic [BIT_WIDTH-1:0] win3,
    output logic [BIT_WIDTH-1:0] win4,
    output logic [BIT_WIDTH-1:0] win5,
    output logic [BIT_WIDTH-1:0] win6,
    output logic [BIT_WIDTH-1:0] win7,
    output logic [BIT_WIDTH-1:0] win8,
    output logic [8:0]           win_sel,
    output logic                 frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [RW-1:0]        row_q, row_d, cur_r;
    logic [CW-1:0]        col_q, col_d, cur_c;
    logic                 accept, emit, last_col, last_px;
    logic                 m_valid_q, m_valid_d, done_q;
    logic [8:0]           mask, sel_q, sel_d;
    logic [BIT_WIDTH-1:0] lb0_rd, lb1_rd;
    logic [BIT_WIDTH-1:0] tap_q [9];
    logic [BIT_WIDTH-1:0] tap_d [9];

    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    // A start-of-frame pixel is treated as (0,0) regardless of where the counters are.
    assign cur_r    = s_sof ? '0 : row_q;
    assign cur_c    = s_sof ? '0 : col_q;
    assign last_col = cur_c == CW'(IMG_W - 1);
    assign last_px  = last_col && cur_r == RW'(IMG_H - 1);
    assign mask     = sel_mask(32'(cur_r), 32'(cur_c));

`ifdef POOL_WIN_PAD_EN
    assign emit  = 1'b1;
    assign sel_d = mask;
`else
    assign emit  = cur_r >= RW'(2) && cur_c >= CW'(2);
    assign sel_d = SEL_ALL;
`endif

    pool_line_buffer #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (cur_c),
        .wdata_i (lb1_rd),
        .rdata_o (lb0_rd)
    );

    pool_line_buffer #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (cur_c),
        .wdata_i (s_data),
        .rdata_o (lb1_rd)
    );

    // Masking the shifted taps also clears the left columns at col 0, so no cross-line bleed.
    always_comb begin
        tap_d[TAP_TL]  = mask[TAP_TL]  ? tap_q[TAP_TC]  : '0;
        tap_d[TAP_TC]  = mask[TAP_TC]  ? tap_q[TAP_TR]  : '0;
        tap_d[TAP_TR]  = mask[TAP_TR]  ? lb0_rd         : '0;
        tap_d[TAP_ML]  = mask[TAP_ML]  ? tap_q[TAP_MC]  : '0;
        tap_d[TAP_MC]  = mask[TAP_MC]  ? tap_q[TAP_MR]  : '0;
        tap_d[TAP_MR]  = mask[TAP_MR]  ? lb1_rd         : '0;
        tap_d[TAP_BL]  = mask[TAP_BL]  ? tap_q[TAP_BC]  : '0;
        tap_d[TAP_BC]  = mask[TAP_BC]  ? tap_q[TAP_CUR] : '0;
        tap_d[TAP_CUR] = mask[TAP_CUR] ? s_data         : '0;
    end

    always_comb begin
        col_d     = !accept ? col_q : last_col ? '0 : cur_c + 1'b1;
        row_d     = !accept ? row_q : !last_col ? cur_r : last_px ? '0 : cur_r + 1'b1;
        m_valid_d = accept ? emit : m_valid_q && !m_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q     <= '0;
            col_q     <= '0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= '0;
            for (int i = 0; i < 9; i++) tap_q[i] <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            m_valid_q <= m_valid_d;
            done_q    <= accept && last_px;
            if (accept) tap_q <= tap_d;
            if (accept && emit) sel_q <= sel_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign win_sel    = sel_q;
    assign frame_done = done_q;
    assign win0       = tap_q[0];
    assign win1       = tap_q[1];
    assign win2       = tap_q[2];
    assign win3       = tap_q[3];
    assign win4       = tap_q[4];
    assign win5       = tap_q[5];
    assign win6       = tap_q[6];
    assign win7       = tap_q[7];
    assign win8       = tap_q[8];
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: directed + randomized stimulus against a frame-image reference model
// (windows read straight from a 2-D pixel array), with a one-deep expected-window queue.
module tb_pool_window_gen;
    localparam int W = 4;
    localparam int H = 4;
`ifdef POOL_WIN_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int WPF = PAD ? W * H : (W - 2) * (H - 2);

    typedef struct packed {
        logic [8:0]  sel;
        logic [71:0] taps;
    } win_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_ready, m_valid, frame_done;
    logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic [8:0] win_sel;

    pool_window_gen #(.BIT_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .win_sel(win_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0, pops = 0, mrow = 0, mcol = 0;
    logic       fd_exp = 1'b0, got_first = 1'b0;
    logic [7:0] img [H][W];
    win_t       q[$];
    win_t       first_obs;

    function automatic logic [71:0] obs_taps();
        return {win8, win7, win6, win5, win4, win3, win2, win1, win0};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic sof);
        int r, c;
        win_t w;
        r = sof ? 0 : mrow;
        c = sof ? 0 : mcol;
        img[r][c] = d;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            int dr, dc;
            dr = 2 - k / 3;
            dc = 2 - k % 3;
            if (r >= dr && c >= dc) begin
                w.taps[k*8 +: 8] = img[r-dr][c-dc];
                w.sel[k] = 1'b1;
            end
        end
        if (PAD || (r >= 2 && c >= 2)) q.push_back(w);
        fd_exp = r == H - 1 && c == W - 1;
        mrow = r;
        mcol = c + 1;
        if (mcol == W) begin
            mcol = 0;
            mrow = (r + 1) % H;
        end
    endtask

    task automatic model_reset();
        q.delete();
        mrow = 0;
        mcol = 0;
        fd_exp = 1'b0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic sof, input logic mr);
        logic rdy;
        @(negedge clk);
        s_valid = v;
        s_data = d;
        s_sof = sof;
        m_ready = mr;
        #1;
        rdy = q.size() == 0 || mr;
        chk("m_valid", 72'(m_valid), 72'(q.size() != 0));
        chk("s_ready", 72'(s_ready), 72'(rdy));
        chk("frame_done", 72'(frame_done), 72'(fd_exp));
        if (q.size() != 0) begin
            chk("win_taps", obs_taps(), q[0].taps);
            chk("win_sel", 72'(win_sel), 72'(q[0].sel));
        end
        fd_exp = 1'b0;
        if (q.size() != 0 && mr) begin
            if (!got_first) begin
                first_obs = '{sel: win_sel, taps: obs_taps()};
                got_first = 1'b1;
            end
            void'(q.pop_front());
            pops++;
        end
        if (v && rdy) model_accept(d, sof);
        @(posedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_m_valid"}, 72'(m_valid), 72'(0));
        chk({tag, "_taps"}, obs_taps(), 72'(0));
        chk({tag, "_sel"}, 72'(win_sel), 72'(0));
        chk({tag, "_frame_done"}, 72'(frame_done), 72'(0));
    endtask

    initial begin
        win_t exp_first;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        model_reset();

        // Plain raster frame 1..16
        pops = 0;
        got_first = 1'b0;
        for (int p = 1; p <= 16; p++) step(1'b1, 8'(p), p == 1, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("win_count_frame", 72'(pops), 72'(WPF));
        exp_first = PAD ? '{sel: 9'b1_0000_0000, taps: {8'd1, 64'd0}}
                        : '{sel: 9'h1FF, taps: {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1}};
        chk("first_window_taps", first_obs.taps, exp_first.taps);
        chk("first_window_sel", 72'(first_obs.sel), 72'(exp_first.sel));

        // Downstream stall for three cycles while a window is held
        pops = 0;
        for (int p = 1; p <= 16; p++) begin
            if (p == 12) repeat (3) step(1'b1, 8'(p), 1'b0, 1'b0);
            step(1'b1, 8'(p), p == 1, 1'b1);
        end
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("win_count_stall", 72'(pops), 72'(WPF));

        // Mid-frame resync on pixel 6
        for (int p = 1; p <= 16; p++) step(1'b1, 8'(p + 32), p == 6, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0);

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        s_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        #2;
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 60) == 0,
                 $urandom_range(0, 2) != 0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
